// File: rtl/writeback_controller_if.sv
// Result handshake from execute plus the BRAM port-B write bus of the writeback controller.
interface writeback_controller_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 13
);
  logic          res_valid;
  logic [N-1:0]  res_data;
  logic          res_ready;
  logic [AW-1:0] addr_b;
  logic [N-1:0]  datain_b;
  logic          en_b;
  logic          wr_b;

  modport master (output res_valid, res_data,
                  input  res_ready, addr_b, datain_b, en_b, wr_b);
  modport slave  (input  res_valid, res_data,
                  output res_ready, addr_b, datain_b, en_b, wr_b);
endinterface

// File: rtl/writeback_controller.sv
// Buffers ALU results in a small FIFO and writes them to BRAM port B at a
// descending, wrapping result pointer; writes pause while the fill path owns the RAM.
module writeback_controller #(
  parameter int unsigned N         = 16,
  parameter int unsigned AW        = 13,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TOP_ADDR  = 8191,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  writeback_controller_if.slave bus,
  input  logic                  stall,
  input  logic                  restart,
  output logic                  busy,
  output logic [AW:0]           wr_count,
  output logic                  wrapped
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [N-1:0]  data_q, data_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wrapped_q, wrapped_d;
  logic          wrap_pend_q, wrap_pend_d;
  logic          push, pop;

  assign push = bus.res_valid && ready_q;

  // Pop decision and state tracking; a pop issues exactly one BRAM write.
  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (occ_q != '0) begin
          pop     = !stall;
          state_d = stall ? HOLD : WRITE;
        end
      end
      WRITE: begin
        if (stall)             state_d = (occ_q != '0) ? HOLD : IDLE;
        else if (occ_q != '0)  pop = 1'b1;
        else                   state_d = IDLE;
      end
      HOLD: begin
        if (!stall && occ_q != '0) begin
          pop     = 1'b1;
          state_d = WRITE;
        end else if (occ_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    occ_d       = occ_q + CW'(push) - CW'(pop);
    ready_d     = (occ_d < CW'(DEPTH));
    addr_d      = addr_q;
    data_d      = data_q;
    wr_d        = pop;
    busy_d      = (occ_d != '0) || pop;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    wrap_pend_d = 1'b0;
    wrapped_d   = wrapped_q | wrap_pend_q;

    if (pop) begin
      addr_d = ptr_q;
      data_d = fifo_q[rd_ptr_q];
      ptr_d  = (ptr_q == AW'(BASE_ADDR)) ? AW'(TOP_ADDR) : ptr_q - AW'(1);
      wrap_pend_d = (ptr_q == AW'(BASE_ADDR));
      if (!(&cnt_q)) cnt_d = cnt_q + (AW+1)'(1);
    end

    // Restart wins over the decrement; a write popping now still used the old pointer.
    if (restart) begin
      ptr_d       = AW'(TOP_ADDR);
      cnt_d       = '0;
      wrapped_d   = 1'b0;
      wrap_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= bus.res_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      ready_q     <= 1'b1;
      ptr_q       <= AW'(TOP_ADDR);
      addr_q      <= AW'(TOP_ADDR);
      data_q      <= '0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      wrapped_q   <= 1'b0;
      wrap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      ready_q     <= ready_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      wrapped_q   <= wrapped_d;
      wrap_pend_q <= wrap_pend_d;
    end
  end

  assign bus.res_ready = ready_q;
  assign bus.addr_b    = addr_q;
  assign bus.datain_b  = data_q;
  assign bus.en_b      = wr_q;
  assign bus.wr_b      = wr_q;
  assign busy          = busy_q;
  assign wr_count      = cnt_q;
  assign wrapped       = wrapped_q;
endmodule

// File: tb/tb_writeback_controller.sv
// Directed bench for writeback_controller with a data scoreboard and small pointer model.
module tb_writeback_controller;
  localparam int unsigned TOP = 8191;

  logic clock, reset, stall, restart;
  logic stall_b, restart_b;
  logic busy, wrapped, busy_b, wrapped_b;
  logic [13:0] wr_count, wr_count_b;

  writeback_controller_if #(.N(16), .AW(13)) ifa ();
  writeback_controller_if #(.N(16), .AW(13)) ifb ();

  writeback_controller dut (
    .clock(clock), .reset(reset), .bus(ifa), .stall(stall), .restart(restart),
    .busy(busy), .wr_count(wr_count), .wrapped(wrapped)
  );

  writeback_controller #(.TOP_ADDR(7), .BASE_ADDR(4)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb), .stall(stall_b), .restart(restart_b),
    .busy(busy_b), .wr_count(wr_count_b), .wrapped(wrapped_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [15:0] mq[$];
  logic [12:0] mptr, exp_addr;
  logic [15:0] exp_data;
  logic [13:0] mcnt;
  logic        mwrap, mpend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mptr = 13'(TOP); exp_addr = 13'(TOP); exp_data = '0;
    mcnt = '0; mwrap = 1'b0; mpend = 1'b0;
  endtask

  // One clock of DUT A: drive, predict, advance, compare.
  task automatic step(input logic v, input logic [15:0] d, input logic s, input logic r,
                      output logic acc);
    logic exp_ready, pop;
    ifa.res_valid = v; ifa.res_data = d; stall = s; restart = r;
    exp_ready = (mq.size() < 4);
    chk("res_ready", 32'(ifa.res_ready), 32'(exp_ready));
    acc = v && exp_ready;
    pop = (mq.size() > 0) && !s;
    mwrap = r ? 1'b0 : (mwrap | mpend);
    mpend = pop && !r && (mptr == 13'd0);
    if (pop) begin
      exp_data = mq.pop_front();
      exp_addr = mptr;
      mptr = (mptr == 13'd0) ? 13'(TOP) : mptr - 13'd1;
      if (mcnt != '1) mcnt = mcnt + 14'd1;
    end
    if (r) begin
      mptr = 13'(TOP);
      mcnt = '0;
    end
    if (acc) mq.push_back(d);
    @(posedge clock); #1;
    chk("wr_b", 32'(ifa.wr_b), 32'(pop));
    chk("en_b", 32'(ifa.en_b), 32'(pop));
    chk("addr_b", 32'(ifa.addr_b), 32'(exp_addr));
    chk("datain_b", 32'(ifa.datain_b), 32'(exp_data));
    chk("wr_count", 32'(wr_count), 32'(mcnt));
    chk("busy", 32'(busy), 32'((mq.size() > 0) || pop));
    chk("wrapped", 32'(wrapped), 32'(mwrap));
  endtask

  task automatic drain(input int n);
    logic a;
    repeat (n) step(1'b0, 16'h0, 1'b0, 1'b0, a);
  endtask

  task automatic apply_reset();
    ifa.res_valid = 1'b0; stall = 1'b0; restart = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic a, done;
    logic [12:0] baddr [6];
    ifa.res_valid = 1'b0; ifa.res_data = '0; stall = 1'b0; restart = 1'b0;
    ifb.res_valid = 1'b0; ifb.res_data = '0; stall_b = 1'b0; restart_b = 1'b0;
    reset = 1'b0;
    apply_reset();

    // Reset state
    chk("rst_addr_b", 32'(ifa.addr_b), TOP);
    chk("rst_datain_b", 32'(ifa.datain_b), 0);
    chk("rst_wr_b", 32'(ifa.wr_b), 0);
    chk("rst_en_b", 32'(ifa.en_b), 0);
    chk("rst_ready", 32'(ifa.res_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(wr_count), 0);
    chk("rst_wrapped", 32'(wrapped), 0);

    // 1: three back-to-back results
    step(1'b1, 16'h1111, 1'b0, 1'b0, a);
    step(1'b1, 16'h2222, 1'b0, 1'b0, a);
    step(1'b1, 16'h3333, 1'b0, 1'b0, a);
    drain(3);
    chk("t1_count", 32'(wr_count), 3);
    chk("t1_busy", 32'(busy), 0);

    // 2: fill under stall, fifth word back-pressured, then release
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'hA0 + i), 1'b1, 1'b0, a);
    chk("t2_fifth_refused", 32'(a), 0);
    done = 1'b0;
    for (int i = 0; i < 6 && !done; i++) begin
      step(1'b1, 16'hA4, 1'b0, 1'b0, a);
      done = a;
    end
    chk("t2_a4_accepted", 32'(done), 1);
    ifa.res_valid = 1'b0;
    drain(5);
    chk("t2_count", 32'(wr_count), 5);

    // 3: small window on instance B wraps 7,6,5,4,7,6
    baddr[0] = 13'd7; baddr[1] = 13'd6; baddr[2] = 13'd5;
    baddr[3] = 13'd4; baddr[4] = 13'd7; baddr[5] = 13'd6;
    for (int k = 0; k < 7; k++) begin
      ifb.res_valid = (k < 6);
      ifb.res_data  = 16'(16'hB0 + k);
      @(posedge clock); #1;
      if (k >= 1) begin
        chk("t3_wr_b", 32'(ifb.wr_b), 1);
        chk("t3_addr_b", 32'(ifb.addr_b), 32'(baddr[k-1]));
        chk("t3_datain_b", 32'(ifb.datain_b), 32'(16'hB0 + k - 1));
      end
      chk("t3_wrapped", 32'(wrapped_b), 32'(k >= 5));
    end
    ifb.res_valid = 1'b0;
    @(posedge clock); #1;
    chk("t3_idle_wr_b", 32'(ifb.wr_b), 0);
    chk("t3_count", 32'(wr_count_b), 6);

    // 4: stall after two of four writes
    apply_reset();
    step(1'b1, 16'hC0, 1'b0, 1'b0, a);
    step(1'b1, 16'hC1, 1'b0, 1'b0, a);
    step(1'b1, 16'hC2, 1'b0, 1'b0, a);
    step(1'b1, 16'hC3, 1'b1, 1'b0, a);
    chk("t4_hold_addr", 32'(ifa.addr_b), 8190);
    step(1'b0, 16'h0, 1'b1, 1'b0, a);
    step(1'b0, 16'h0, 1'b1, 1'b0, a);
    chk("t4_hold_addr2", 32'(ifa.addr_b), 8190);
    drain(4);

    // 5: restart coincides with the write to 8185
    apply_reset();
    for (int i = 0; i < 9; i++)
      step(i < 8, 16'(16'hD0 + i), 1'b0, i == 7, a);
    chk("t5_next_addr", 32'(ifa.addr_b), TOP);
    chk("t5_wrapped", 32'(wrapped), 0);
    drain(3);

    // 6: asynchronous reset mid-cycle with three words queued and a write in flight
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'hE0 + i), 1'b1, 1'b0, a);
    step(1'b0, 16'h0, 1'b0, 1'b0, a);
    #1 reset = 1'b1;
    #1;
    chk("t6_wr_b", 32'(ifa.wr_b), 0);
    chk("t6_en_b", 32'(ifa.en_b), 0);
    chk("t6_addr_b", 32'(ifa.addr_b), TOP);
    chk("t6_ready", 32'(ifa.res_ready), 1);
    chk("t6_busy", 32'(busy), 0);
    #1 reset = 1'b0;
    model_reset();
    drain(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
